// File: rtl/gold_code_correlator.sv
// Serial correlator against a local GPS C/A Gold code: one-chip slip search, lock tracking.
// Optional GOLD_CORR_POLARITY_EN accepts inverted (data-modulated) code and reports its sign.
module gold_code_correlator #(
    parameter int unsigned G2_TAP_A  = 2,
    parameter int unsigned G2_TAP_B  = 6,
    parameter int unsigned THRESH    = 800,
    parameter int unsigned LOCK_LOSS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        chip_in,
    input  logic        chip_valid,
    input  logic        load_gold,
    output logic [10:0] corr_out,
    output logic        corr_valid,
    output logic        locked,
    output logic [9:0]  code_phase,
    output logic        data_bit
);

    localparam int unsigned CW         = 11;
    localparam int unsigned PW         = 10;
    localparam int unsigned MW         = (LOCK_LOSS < 2) ? 1 : $clog2(LOCK_LOSS + 1);
    localparam logic [PW-1:0] LAST_CHIP = PW'(1022);

    typedef enum logic {SEARCH, LOCK} state_t;

    state_t          state;
    logic [10:1]     g1;
    logic [10:1]     g2;
    logic [PW-1:0]   chip_cnt;
    logic [CW-1:0]   agree;
    logic [MW-1:0]   miss_cnt;
    logic            slip_pending;

    logic            g1_fb_c;
    logic            g2_fb_c;
    logic            local_chip_c;
    logic [CW-1:0]   agree_next_c;
    logic [CW-1:0]   metric_c;
    logic            sign_c;
    logic            hit_c;
    logic [MW-1:0]   miss_inc_c;
    logic            lost_c;

    // Local code and the running metric including the chip being consumed this cycle
    always_comb begin
        g1_fb_c      = g1[3] ^ g1[10];
        g2_fb_c      = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
        local_chip_c = g1[10] ^ g2[G2_TAP_A] ^ g2[G2_TAP_B];
        agree_next_c = agree + CW'(chip_in == local_chip_c);
`ifdef GOLD_CORR_POLARITY_EN
        metric_c = (agree_next_c >= (CW'(1023) - agree_next_c)) ? agree_next_c
                                                               : (CW'(1023) - agree_next_c);
        sign_c   = (agree_next_c < CW'(512));
`else
        metric_c = agree_next_c;
        sign_c   = 1'b0;
`endif
        hit_c      = (metric_c >= CW'(THRESH));
        miss_inc_c = miss_cnt + MW'(1);
        lost_c     = (miss_inc_c >= MW'(LOCK_LOSS));
    end

    always_ff @(posedge clk) begin
        if (rst || load_gold) begin
            state        <= SEARCH;
            g1           <= '1;
            g2           <= '1;
            chip_cnt     <= '0;
            agree        <= '0;
            miss_cnt     <= '0;
            slip_pending <= 1'b0;
            corr_out     <= '0;
            corr_valid   <= 1'b0;
            locked       <= 1'b0;
            code_phase   <= '0;
            data_bit     <= 1'b0;
        end else begin
            corr_valid <= 1'b0;
            if (chip_valid) begin
                if (slip_pending) begin
                    // Discarded chip: local code holds, so it falls one chip behind the input
                    slip_pending <= 1'b0;
                    code_phase   <= (code_phase == LAST_CHIP) ? '0 : code_phase + PW'(1);
                end else if (chip_cnt == LAST_CHIP) begin
                    chip_cnt   <= '0;
                    agree      <= '0;
                    g1         <= '1;
                    g2         <= '1;
                    corr_valid <= 1'b1;
                    corr_out   <= metric_c;
                    data_bit   <= sign_c;
                    case (state)
                        SEARCH: begin
                            if (hit_c) begin
                                state    <= LOCK;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end else begin
                                slip_pending <= 1'b1;
                            end
                        end
                        LOCK: begin
                            if (hit_c) begin
                                miss_cnt <= '0;
                            end else if (lost_c) begin
                                state    <= SEARCH;
                                locked   <= 1'b0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_inc_c;
                            end
                        end
                        default: state <= SEARCH;
                    endcase
                end else begin
                    chip_cnt <= chip_cnt + PW'(1);
                    agree    <= agree_next_c;
                    g1       <= {g1[9:1], g1_fb_c};
                    g2       <= {g2[9:1], g2_fb_c};
                end
            end
        end
    end

endmodule

// File: tb/tb_gold_code_correlator.sv
// Scoreboard bench for gold_code_correlator: directed PRN 1 streams, expected period results queued.
module tb_gold_code_correlator;

    logic        clk = 1'b0;
    logic        rst;
    logic        chip_in;
    logic        chip_valid;
    logic        load_gold;
    logic [10:0] corr_out;
    logic        corr_valid;
    logic        locked;
    logic [9:0]  code_phase;
    logic        data_bit;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int cyc;
        int corr;
        bit miss;
        bit lck;
        int phase;
        bit db;
    } exp_t;

    exp_t q[$];
    bit   prn[0:1022];

`ifdef GOLD_CORR_POLARITY_EN
    localparam int INV_CORR = 1023;
    localparam bit INV_LCK  = 1'b1;
    localparam bit INV_DB   = 1'b1;
    localparam int ZERO_CORR = 512;
    localparam bit ZERO_DB  = 1'b1;
    localparam int MISS_A = 512, MISS_B = 544, MISS_C = 543;
`else
    localparam int INV_CORR = 0;
    localparam bit INV_LCK  = 1'b0;
    localparam bit INV_DB   = 1'b0;
    localparam int ZERO_CORR = 511;
    localparam bit ZERO_DB  = 1'b0;
    localparam int MISS_A = 479, MISS_B = 511, MISS_C = 543;
`endif

    gold_code_correlator dut (
        .clk        (clk),
        .rst        (rst),
        .chip_in    (chip_in),
        .chip_valid (chip_valid),
        .load_gold  (load_gold),
        .corr_out   (corr_out),
        .corr_valid (corr_valid),
        .locked     (locked),
        .code_phase (code_phase),
        .data_bit   (data_bit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every corr_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (corr_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_corr_valid actual=1 required=0 corr_out=%0d (cycle %0d)",
                         corr_out, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("corr_valid_cycle", cyc, e.cyc);
                if (e.miss) begin
                    checks++;
                    if (!(corr_out == 11'(MISS_A) || corr_out == 11'(MISS_B) || corr_out == 11'(MISS_C))) begin
                        failures++;
                        $display("FAIL corr_out_miss actual=%0d required=one of %0d/%0d/%0d",
                                 corr_out, MISS_A, MISS_B, MISS_C);
                    end
                end else begin
                    chk("corr_out", int'(corr_out), e.corr);
                    chk("data_bit", int'(data_bit), int'(e.db));
                end
                chk("locked", int'(locked), int'(e.lck));
                chk("code_phase", int'(code_phase), e.phase);
            end
        end
    end

    task automatic send(input logic c, input logic v, input logic ld);
        @(negedge clk);
        chip_in    = c;
        chip_valid = v;
        load_gold  = ld;
    endtask

    // Called right after the 1023rd counted chip is driven; result due one cycle later
    task automatic push(input int corr, input bit miss, input bit lck, input int phase, input bit db);
        exp_t e;
        e.cyc   = cyc + 1;
        e.corr  = corr;
        e.miss  = miss;
        e.lck   = lck;
        e.phase = phase;
        e.db    = db;
        q.push_back(e);
    endtask

    // mode 0: PRN 1, mode 1: inverted PRN 1, mode 2: all zeros; gap idle cycles after each chip
    task automatic feed_period(input int mode, input int gap, input int corr, input bit lck,
                               input int phase, input bit db);
        for (int k = 0; k < 1023; k++) begin
            logic c;
            c = (mode == 2) ? 1'b0 : (prn[k] ^ (mode == 1));
            send(c, 1'b1, 1'b0);
            if (k == 1022) push(corr, 1'b0, lck, phase, db);
            for (int g = 0; g < gap; g++) send(~c, 1'b0, 1'b0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 10) begin
            send(1'b0, 1'b0, 1'b0);
            n++;
        end
        send(1'b0, 1'b0, 1'b0);
        chk("pending_results", q.size(), 0);
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; chip_in = 1'b0; chip_valid = 1'b0; load_gold = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_corr_out", int'(corr_out), 0);
        chk("rst_corr_valid", int'(corr_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_code_phase", int'(code_phase), 0);
        chk("rst_data_bit", int'(data_bit), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int s1 [1:10];
        int s2 [1:10];
        int f1, f2, t;
        for (int i = 1; i <= 10; i++) begin s1[i] = 1; s2[i] = 1; end
        for (int k = 0; k < 1023; k++) begin
            prn[k] = bit'(s1[10] ^ s2[2] ^ s2[6]);
            f1 = s1[3] ^ s1[10];
            f2 = s2[2] ^ s2[3] ^ s2[6] ^ s2[8] ^ s2[9] ^ s2[10];
            for (int i = 10; i > 1; i--) begin s1[i] = s1[i-1]; s2[i] = s2[i-1]; end
            s1[1] = f1;
            s2[1] = f2;
        end

        // Aligned PRN 1: immediate lock, stays locked next period
        do_reset();
        feed_period(0, 0, 1023, 1'b1, 0, 1'b0);
        feed_period(0, 0, 1023, 1'b1, 0, 1'b0);
        drain();

        // Inverted code
        do_reset();
        feed_period(1, 0, INV_CORR, INV_LCK, 0, INV_DB);
        drain();

        // Input delayed 5 chips: five misses with one slip each, then lock
        do_reset();
        t = 0;
        for (int p = 1; p <= 6; p++) begin
            if (p > 1) begin
                send(prn[(t + 1023 - 5) % 1023], 1'b1, 1'b0);
                t++;
            end
            for (int k = 0; k < 1023; k++) begin
                send(prn[(t + 1023 - 5) % 1023], 1'b1, 1'b0);
                t++;
                if (k == 1022) push(1023, p < 6, p == 6, p - 1, 1'b0);
            end
        end
        drain();

        // Lock, then constant zero input: lock survives two misses, drops on the third
        do_reset();
        feed_period(0, 0, 1023, 1'b1, 0, 1'b0);
        feed_period(2, 0, ZERO_CORR, 1'b1, 0, ZERO_DB);
        feed_period(2, 0, ZERO_CORR, 1'b1, 0, ZERO_DB);
        feed_period(2, 0, ZERO_CORR, 1'b0, 0, ZERO_DB);
        drain();

        // Mid-period restart with a coincident valid chip that must be dropped
        do_reset();
        feed_period(0, 0, 1023, 1'b1, 0, 1'b0);
        for (int k = 0; k < 400; k++) send(prn[k], 1'b1, 1'b0);
        send(prn[0], 1'b1, 1'b1);
        send(1'b0, 1'b0, 1'b0);
        chk("load_locked", int'(locked), 0);
        chk("load_corr_out", int'(corr_out), 0);
        chk("load_corr_valid", int'(corr_valid), 0);
        chk("load_code_phase", int'(code_phase), 0);
        feed_period(0, 0, 1023, 1'b1, 0, 1'b0);
        drain();

        // Sparse chip_valid (1 in 3)
        do_reset();
        feed_period(0, 2, 1023, 1'b1, 0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
